// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding constants, op classes and loader state type.
// Opcodes must stay in step with controlDecoder.
package riscv_enc_pkg;

  typedef enum logic [1:0] {
    OpLw    = 2'd0,
    OpSw    = 2'd1,
    OpRtype = 2'd2,
    OpBeq   = 2'd3
  } op_class_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder: instruction fields to a 32-bit machine word.
module instr_encoder
  import riscv_enc_pkg::*;
(
  input  op_class_t   op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    unique case (op)
      OpLw:    word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      OpSw:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      OpRtype: word = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
      OpBeq:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Streams encoded instructions into instruction memory, one per cycle, holding the CPU
// off via busy. Optional immediate range/alignment checking under LOADER_IMM_CHECK_EN.
module imem_program_loader
  import riscv_enc_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  loader_state_t   stateQ;
  logic [ADDR_W:0] countQ;
  logic            ovfQ;
  logic [31:0]     encWord;
  logic            accept;
  logic            immBad;

  instr_encoder uEnc (
    .op     (op_class_t'(in_op)),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (encWord)
  );

  assign in_ready = (stateQ == StLoad) && (countQ < DepthCnt);
  assign accept   = in_valid && in_ready;
  assign busy     = (stateQ == StLoad) || (stateQ == StDrain);
  assign done     = (stateQ == StDone);
  assign count    = countQ;

`ifdef LOADER_IMM_CHECK_EN
  // LW/SW immediates must fit 12-bit signed; branch targets must be halfword aligned.
  always_comb begin
    immBad = 1'b0;
    case (op_class_t'(in_op))
      OpLw, OpSw: immBad = in_imm[12] ^ in_imm[11];
      OpBeq:      immBad = in_imm[0];
      default:    immBad = 1'b0;
    endcase
  end
`else
  assign immBad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      countQ     <= '0;
      ovfQ       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (stateQ)
        StIdle, StDone: begin
          if (start) begin
            stateQ <= StLoad;
            countQ <= '0;
            ovfQ   <= 1'b0;
            err    <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= countQ[ADDR_W-1:0];
            imem_wdata <= encWord;
            countQ     <= countQ + 1'b1;
            if (immBad) err <= 1'b1;
            if (in_last || (countQ + 1'b1 == DepthCnt)) begin
              stateQ <= StDrain;
              ovfQ   <= !in_last;
            end
          end
        end
        StDrain: begin
          stateQ <= StDone;
          if (ovfQ) err <= 1'b1;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboarded randomized bench for imem_program_loader (DEPTH=4).
module tb_imem_program_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
`ifdef LOADER_IMM_CHECK_EN
  localparam bit ImmChk = 1'b1;
`else
  localparam bit ImmChk = 1'b0;
`endif

  typedef struct {
    int addr;
    logic [31:0] word;
  } wr_t;

  typedef struct {
    int op, rd, rs1, rs2, f3, f7, imm;
    bit last;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [1:0] in_op = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic [6:0] in_funct7 = '0;
  logic [12:0] in_imm = '0;
  logic in_ready, imem_we, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [ADDR_W:0] count;

  int checks = 0;
  int errors = 0;
  wr_t expQ[$];
  bit mLoad = 1'b0;
  int mCount = 0;
  bit mErr = 1'b0;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the field layout, using plain shifts on integers.
  function automatic logic [31:0] refEnc(input instr_t i);
    int unsigned w;
    int unsigned imm = i.imm;
    case (i.op)
      0: w = ((imm & 'hFFF) << 20) | (i.rs1 << 15) | (i.f3 << 12) | (i.rd << 7) | 'h03;
      1: w = (((imm >> 5) & 'h7F) << 25) | (i.rs2 << 20) | (i.rs1 << 15) | (i.f3 << 12)
             | ((imm & 'h1F) << 7) | 'h23;
      2: w = (i.f7 << 25) | (i.rs2 << 20) | (i.rs1 << 15) | (i.f3 << 12) | (i.rd << 7) | 'h33;
      default: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (i.rs2 << 20)
                   | (i.rs1 << 15) | (i.f3 << 12) | (((imm >> 1) & 'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | 'h63;
    endcase
    return w;
  endfunction

  function automatic bit immOutOfRange(input instr_t i);
    int s = (i.imm >= 4096) ? i.imm - 8192 : i.imm;
    if (i.op == 0 || i.op == 1) return (s < -2048) || (s > 2047);
    if (i.op == 3) return (i.imm % 2) == 1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = expQ.pop_front();
        check("write_addr", 32'(imem_addr), e.addr);
        check("write_data", imem_wdata, e.word);
      end
    end
  end

  // One input cycle; the model decides acceptance and queues the expected write.
  task automatic drive(input bit v, input instr_t i, input bit useLit, input logic [31:0] lit);
    bit expReady;
    in_valid  = v;
    in_op     = i.op[1:0];
    in_rd     = i.rd[4:0];
    in_rs1    = i.rs1[4:0];
    in_rs2    = i.rs2[4:0];
    in_funct3 = i.f3[2:0];
    in_funct7 = i.f7[6:0];
    in_imm    = i.imm[12:0];
    in_last   = i.last;
    @(negedge clk);
    expReady = mLoad && (mCount < DEPTH);
    check("in_ready", 32'(in_ready), 32'(expReady));
    if (v && expReady) begin
      expQ.push_back('{addr: mCount, word: (useLit ? lit : refEnc(i))});
      mCount++;
      if (ImmChk && immOutOfRange(i)) mErr = 1'b1;
      if (i.last || mCount == DEPTH) begin
        mLoad = 1'b0;
        if (!i.last) mErr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    instr_t z = '{default: 0};
    for (int k = 0; k < n; k++) drive(1'b0, z, 1'b0, 32'h0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mLoad = 1'b1;
    mCount = 0;
    mErr = 1'b0;
  endtask

  task automatic finishSession();
    bit seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("done", 32'(done), 32'h1);
    check("count", 32'(count), mCount);
    check("err", 32'(err), 32'(mErr));
    check("busy_done", 32'(busy), 32'h0);
    check("queue_drained", expQ.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCleared(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'h0);
    check({tag, "_addr"}, 32'(imem_addr), 32'h0);
    check({tag, "_wdata"}, imem_wdata, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_ready"}, 32'(in_ready), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    instr_t r;
    instr_t ins;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkCleared("reset");
    @(posedge clk);
    #1;

    // Single RTYPE.
    pulseStart();
    drive(1'b1, '{op: 2, rd: 3, rs1: 1, rs2: 2, f3: 0, f7: 0, imm: 0, last: 1'b1}, 1'b1,
          32'h002081B3);
    finishSession();

    // Back-to-back LW, SW, BEQ.
    pulseStart();
    drive(1'b1, '{op: 0, rd: 5, rs1: 0, rs2: 0, f3: 2, f7: 0, imm: 8, last: 1'b0}, 1'b1,
          32'h00802283);
    drive(1'b1, '{op: 1, rd: 0, rs1: 0, rs2: 5, f3: 2, f7: 0, imm: 12, last: 1'b0}, 1'b1,
          32'h00502623);
    drive(1'b1, '{op: 3, rd: 0, rs1: 1, rs2: 2, f3: 0, f7: 0, imm: 8188, last: 1'b1}, 1'b1,
          32'hFE208EE3);
    finishSession();

    // Overflow: five offered, none last.
    pulseStart();
    for (int k = 0; k < 5; k++)
      drive(1'b1, '{op: 2, rd: k + 1, rs1: k, rs2: 7, f3: 0, f7: 32, imm: 0, last: 1'b0},
            1'b0, 32'h0);
    finishSession();

    // Start from DONE clears count and err.
    pulseStart();
    @(negedge clk);
    check("restart_count", 32'(count), 32'h0);
    check("restart_err", 32'(err), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1;

    // Reset mid-session, coincident with a third in_valid.
    drive(1'b1, '{op: 0, rd: 1, rs1: 2, rs2: 0, f3: 2, f7: 0, imm: 4, last: 1'b0}, 1'b0, 32'h0);
    drive(1'b1, '{op: 0, rd: 2, rs1: 2, rs2: 0, f3: 2, f7: 0, imm: 8, last: 1'b0}, 1'b0, 32'h0);
    in_valid = 1'b1;
    in_op    = 2'd2;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    mLoad = 1'b0;
    mCount = 0;
    mErr = 1'b0;
    @(negedge clk);
    checkCleared("midreset");
    check("midreset_queue", expQ.size(), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    pulseStart();
    drive(1'b1, '{op: 2, rd: 9, rs1: 3, rs2: 4, f3: 7, f7: 0, imm: 0, last: 1'b1}, 1'b0, 32'h0);
    finishSession();

    // Gap mid-stream.
    pulseStart();
    drive(1'b1, '{op: 0, rd: 4, rs1: 6, rs2: 0, f3: 2, f7: 0, imm: 100, last: 1'b0}, 1'b0, 32'h0);
    drive(1'b1, '{op: 1, rd: 0, rs1: 6, rs2: 4, f3: 2, f7: 0, imm: 8000, last: 1'b0}, 1'b0,
          32'h0);
    idle(3);
    drive(1'b1, '{op: 2, rd: 8, rs1: 4, rs2: 5, f3: 0, f7: 32, imm: 0, last: 1'b1}, 1'b0, 32'h0);
    finishSession();

    // Misaligned branch immediate.
    pulseStart();
    drive(1'b1, '{op: 3, rd: 0, rs1: 1, rs2: 2, f3: 1, f7: 0, imm: 5, last: 1'b1}, 1'b0, 32'h0);
    finishSession();

    // Randomized sessions with random gaps, ops, fields and last placement.
    for (int s = 0; s < 12; s++) begin
      pulseStart();
      for (int k = 0; k < 40 && mLoad; k++) begin
        r.op   = int'($urandom_range(0, 3));
        r.rd   = int'($urandom_range(0, 31));
        r.rs1  = int'($urandom_range(0, 31));
        r.rs2  = int'($urandom_range(0, 31));
        r.f3   = int'($urandom_range(0, 7));
        r.f7   = int'($urandom_range(0, 127));
        r.imm  = int'($urandom_range(0, 8191));
        r.last = ($urandom_range(0, 3) == 0);
        ins = r;
        drive($urandom_range(0, 3) != 0, ins, 1'b0, 32'h0);
      end
      if (mLoad) begin
        checks++;
        errors++;
        $display("FAIL session_bound: got session still open expected closed");
        mLoad = 1'b0;
      end
      finishSession();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Encoder/writer counterpart to the control decoder: accepts instruction fields (lw, sw, R-type, beq), encodes each into a 32-bit RV32I machine word, and writes it sequentially into instruction memory.
- Sits between the test/boot environment and the single-cycle CPU's instruction memory write port.
- Holds the CPU off via `busy` while loading.
- Streams one instruction per cycle with a one-stage registered encode pipeline.

Parameters:
- DEPTH, 64, instruction memory capacity in words.
- ADDR_W, $clog2(DEPTH), word-address width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load session.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader can accept an instruction.
- in_last  input  1  qualifies in_valid; marks the final instruction.
- in_op  input  2  op class: 0=LW, 1=SW, 2=RTYPE, 3=BEQ.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field; used by RTYPE only.
- in_imm  input  13  signed immediate; bits [11:0] for LW/SW, [12:1] for BEQ.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD and DRAIN.
- done  output  1  high in DONE.
- count  output  ADDR_W+1  number of instructions accepted this session.
- err  output  1  sticky session error.

Behaviour:
- Reset: state IDLE; all outputs 0. A reset asserted mid-session aborts it: no further writes, and `imem_we` is 0 in the first cycle after the reset edge.
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN on an accept with `in_last`, or on an accept that makes count==DEPTH.
  - DRAIN → DONE after the pending write issues (one cycle).
  - DONE → LOAD on `start`; clears count and err.
  - `start` is ignored in LOAD and DRAIN.
- Handshake:
  - `in_ready` = (state==LOAD) && (count<DEPTH).
  - Accept = in_valid && in_ready. Inputs are ignored when not accepted.
- Latency: an accept in cycle N gives imem_we=1 in cycle N+1, with imem_addr = count before the accept and imem_wdata = the encoded word. Back-to-back accepts write every cycle.
- count increments on each accept.
- Encoding (opcode constants must match the decoder):
  - LW: imm[11:0] | rs1 | f3 | rd | 0000011
  - SW: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | 0100011
  - RTYPE: f7 | rs2 | rs1 | f3 | rd | 0110011
  - BEQ: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | 1100011
- Overflow: if the DEPTH-th accept lacks `in_last`, that word is still written, then err=1 when entering DONE. No further accepts occur (`in_ready`=0).
- `err` holds until the next `start` or reset.

Optional Feature:
- Macro: LOADER_IMM_CHECK_EN
- Defined: an accept sets err (sticky) on either of these:
  - LW/SW with in_imm[12] != in_imm[11] (value does not fit 12-bit signed);
  - BEQ with in_imm[0]=1 (misaligned).
  
  The word is still written and the session continues.
- Undefined: out-of-range bits are silently truncated; err is set only by overflow.

Decomposition:
- Package `riscv_enc_pkg`:
  - op_class_t enum (LW, SW, RTYPE, BEQ);
  - 7-bit opcode localparams OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_BRANCH, shared with controlDecoder;
  - loader state enum.
- Sub-module `instr_encoder`: purely combinational; fields → 32-bit word. The loader registers its output.

Test Plan:
- Single instruction:
  - Stimulus: start; accept RTYPE rd=3 rs1=1 rs2=2 f3=0 f7=0 with last.
  - Response: next cycle imem_we=1, addr=0, wdata=0x002081B3; then DONE, count=1, err=0.
- Back-to-back stream, `in_valid` held every cycle:
  - Stimulus: LW rd=5 rs1=0 f3=010 imm=8; SW rs2=5 rs1=0 f3=010 imm=12; BEQ rs1=1 rs2=2 f3=0 imm=-4 (last).
  - Response: consecutive writes addr 0,1,2 = 0x00802283, 0x00502623, 0xFE208EE3.
- Overflow with DEPTH=4:
  - Stimulus: 5 instructions offered, none marked last.
  - Response: 4 writes at addr 0..3; in_ready low after the 4th accept; done=1, err=1, count=4.
- Reset mid-session:
  - Stimulus: after 2 accepts, assert reset coincident with a 3rd in_valid.
  - Response: that instruction is not written; all outputs 0; IDLE; a later start restarts at addr 0.
- Gap and restart:
  - Stimulus: in_valid low for 3 cycles mid-stream.
  - Response: no imem_we during the gap, addresses stay contiguous; start in DONE clears count and err.
- LOADER_IMM_CHECK_EN:
  - Stimulus: BEQ imm=5.
  - Response: err=1 and the word is written. With the macro undefined, err=0.
